// File: rtl/bcd_countdown_999_if.sv
// Control/status bundle for the three-digit BCD countdown timer.
//   tick, load, load_value, start, pause : controller -> timer
//   time_out, done, running              : timer -> controller
// master = controller side, slave = timer side.
interface bcd_countdown_999_if;
  logic        tick;
  logic        load;
  logic [11:0] load_value;
  logic        start;
  logic        pause;
  logic [11:0] time_out;
  logic        done;
  logic        running;

  modport master (
    output tick, load, load_value, start, pause,
    input  time_out, done, running
  );

  modport slave (
    input  tick, load, load_value, start, pause,
    output time_out, done, running
  );
endinterface

// File: rtl/bcd_countdown_999.sv
// Three-digit BCD countdown timer (999 down to 000) with optional auto reload.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : slave side of bcd_countdown_999_if
//           inputs  tick, load, load_value[11:0], start, pause
//           outputs time_out[11:0] (BCD h/t/u), done (expiry pulse), running
// Per-cycle input priority is load > pause > start > tick; an asserted
// higher-priority input masks the lower ones even when it has no effect.
module bcd_countdown_999 #(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  bcd_countdown_999_if.slave bus
);

  localparam int unsigned DIG_W = 4;
  localparam int unsigned CNT_W = 3 * DIG_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   time_q, time_d;
  logic [CNT_W-1:0]   reload_q, reload_d;
  logic               done_q, done_d;
  logic               running_q, running_d;
  logic [CNT_W-1:0]   load_clamped;

  // Saturate a non-BCD digit to 9.
  function automatic logic [DIG_W-1:0] clamp_digit(input logic [DIG_W-1:0] d);
    return (d > DIG_W'(9)) ? DIG_W'(9) : d;
  endfunction

  // BCD decrement with borrow ripple; 000 is held rather than wrapped.
  function automatic logic [CNT_W-1:0] bcd_dec(input logic [CNT_W-1:0] v);
    logic [DIG_W-1:0] h, t, u;
    {h, t, u} = v;
    if (v == CNT_W'(0)) return v;
    if (u != DIG_W'(0)) begin
      u = u - DIG_W'(1);
    end else begin
      u = DIG_W'(9);
      if (t != DIG_W'(0)) begin
        t = t - DIG_W'(1);
      end else begin
        t = DIG_W'(9);
        h = h - DIG_W'(1);
      end
    end
    return {h, t, u};
  endfunction

  assign load_clamped = {clamp_digit(bus.load_value[11:8]),
                         clamp_digit(bus.load_value[7:4]),
                         clamp_digit(bus.load_value[3:0])};

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      time_q    <= CNT_W'(0);
      reload_q  <= CNT_W'(0);
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      reload_q  <= reload_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (bus.load) begin
      time_d   = load_clamped;
      reload_d = load_clamped;
      state_d  = IDLE;
    end else if (bus.pause) begin
      if (state_q == RUN) state_d = HOLD;
    end else if (bus.start) begin
      if ((state_q == IDLE && time_q != CNT_W'(0)) || state_q == HOLD) begin
        state_d = RUN;
      end
    end else if (bus.tick && state_q == RUN) begin
      if (time_q == CNT_W'(1)) begin
        done_d = 1'b1;
        // An all-zero reload register degrades auto reload to a plain stop.
        if (AUTO_RELOAD && reload_q != CNT_W'(0)) begin
          time_d = reload_q;
        end else begin
          time_d  = CNT_W'(0);
          state_d = IDLE;
        end
      end else begin
        time_d = bcd_dec(time_q);
      end
    end

    running_d = (state_d == RUN);
  end

  assign bus.time_out = time_q;
  assign bus.done     = done_q;
  assign bus.running  = running_q;

endmodule

// File: tb/tb_bcd_countdown_999.sv
// Self-checking bench: two timers (AUTO_RELOAD 0 and 1) driven with the same
// inputs, checked against a decimal reference model, a directed vector table,
// hand-written corner sequences and random stimulus.
module tb_bcd_countdown_999;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bcd_countdown_999_if if0();
  bcd_countdown_999_if if1();

  bcd_countdown_999 #(.AUTO_RELOAD(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  bcd_countdown_999 #(.AUTO_RELOAD(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: count kept as a plain decimal integer.
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;
  int m_cnt[2];
  int m_rel[2];
  int m_st[2];
  int m_done[2];

  typedef struct {
    bit          ld;
    logic [11:0] lv;
    bit          st;
    bit          ps;
    bit          tk;
    logic [11:0] et;
    bit          ed;
    bit          er;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(bit ld, logic [11:0] lv, bit st, bit ps, bit tk,
                              logic [11:0] et, bit ed, bit er);
    vec_t v;
    v.ld = ld; v.lv = lv; v.st = st; v.ps = ps; v.tk = tk;
    v.et = et; v.ed = ed; v.er = er;
    return v;
  endfunction

  function automatic logic [11:0] to_bcd(int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int clamp_dec(logic [11:0] lv);
    int h, t, u;
    h = (int'(lv[11:8]) > 9) ? 9 : int'(lv[11:8]);
    t = (int'(lv[7:4])  > 9) ? 9 : int'(lv[7:4]);
    u = (int'(lv[3:0])  > 9) ? 9 : int'(lv[3:0]);
    return h * 100 + t * 10 + u;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_rel[k] = 0; m_st[k] = M_IDLE; m_done[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit ar, input bit ld, input logic [11:0] lv,
                            input bit st, input bit ps, input bit tk);
    m_done[k] = 0;
    if (ld) begin
      m_cnt[k] = clamp_dec(lv);
      m_rel[k] = m_cnt[k];
      m_st[k]  = M_IDLE;
    end else if (ps) begin
      if (m_st[k] == M_RUN) m_st[k] = M_HOLD;
    end else if (st) begin
      if (m_st[k] == M_HOLD || (m_st[k] == M_IDLE && m_cnt[k] > 0)) m_st[k] = M_RUN;
    end else if (tk && m_st[k] == M_RUN) begin
      if (m_cnt[k] == 1) begin
        m_done[k] = 1;
        if (ar && m_rel[k] > 0) m_cnt[k] = m_rel[k];
        else begin
          m_cnt[k] = 0;
          m_st[k]  = M_IDLE;
        end
      end else if (m_cnt[k] > 0) begin
        m_cnt[k] = m_cnt[k] - 1;
      end
    end
  endtask

  task automatic check_model();
    check("ar0 time_out", 32'(if0.time_out), 32'(to_bcd(m_cnt[0])));
    check("ar0 done",     32'(if0.done),     m_done[0]);
    check("ar0 running",  32'(if0.running),  (m_st[0] == M_RUN) ? 1 : 0);
    check("ar1 time_out", 32'(if1.time_out), 32'(to_bcd(m_cnt[1])));
    check("ar1 done",     32'(if1.done),     m_done[1]);
    check("ar1 running",  32'(if1.running),  (m_st[1] == M_RUN) ? 1 : 0);
  endtask

  // Apply one cycle of inputs to both timers, advance one edge, check model.
  task automatic step(input bit ld, input logic [11:0] lv, input bit st,
                      input bit ps, input bit tk);
    if0.load = ld; if0.load_value = lv; if0.start = st; if0.pause = ps; if0.tick = tk;
    if1.load = ld; if1.load_value = lv; if1.start = st; if1.pause = ps; if1.tick = tk;
    model_step(0, 1'b0, ld, lv, st, ps, tk);
    model_step(1, 1'b1, ld, lv, st, ps, tk);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check("reset time_out", 32'(if0.time_out), 0);
    check("reset running",  32'(if0.running),  0);
    check("reset done",     32'(if1.done),     0);
    check("reset time_out1", 32'(if1.time_out), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    if0.load = 1'b0; if0.load_value = 12'h000; if0.start = 1'b0; if0.pause = 1'b0; if0.tick = 1'b0;
    if1.load = 1'b0; if1.load_value = 12'h000; if1.start = 1'b0; if1.pause = 1'b0; if1.tick = 1'b0;
    do_reset();

    // Directed table, expectations for the non-reloading timer.
    vecs[0]  = mk(1, 12'h003, 0, 0, 0, 12'h003, 0, 0);
    vecs[1]  = mk(0, 12'h000, 1, 0, 0, 12'h003, 0, 1);
    vecs[2]  = mk(0, 12'h000, 0, 0, 1, 12'h002, 0, 1);
    vecs[3]  = mk(0, 12'h000, 0, 0, 1, 12'h001, 0, 1);
    vecs[4]  = mk(0, 12'h000, 0, 0, 1, 12'h000, 1, 0);
    vecs[5]  = mk(0, 12'h000, 0, 0, 0, 12'h000, 0, 0);
    vecs[6]  = mk(1, 12'h100, 0, 0, 0, 12'h100, 0, 0);
    vecs[7]  = mk(0, 12'h000, 1, 0, 0, 12'h100, 0, 1);
    vecs[8]  = mk(0, 12'h000, 0, 0, 1, 12'h099, 0, 1);
    vecs[9]  = mk(1, 12'h010, 0, 0, 0, 12'h010, 0, 0);
    vecs[10] = mk(0, 12'h000, 1, 0, 0, 12'h010, 0, 1);
    vecs[11] = mk(0, 12'h000, 0, 0, 1, 12'h009, 0, 1);
    vecs[12] = mk(1, 12'hAF5, 0, 0, 0, 12'h995, 0, 0);
    vecs[13] = mk(1, 12'h000, 0, 0, 0, 12'h000, 0, 0);
    vecs[14] = mk(0, 12'h000, 1, 0, 0, 12'h000, 0, 0);
    vecs[15] = mk(1, 12'h051, 0, 0, 0, 12'h051, 0, 0);
    vecs[16] = mk(0, 12'h000, 1, 0, 0, 12'h051, 0, 1);
    vecs[17] = mk(0, 12'h000, 0, 0, 1, 12'h050, 0, 1);
    vecs[18] = mk(0, 12'h000, 0, 1, 1, 12'h050, 0, 0);
    vecs[19] = mk(0, 12'h000, 0, 0, 1, 12'h050, 0, 0);
    vecs[20] = mk(0, 12'h000, 1, 0, 0, 12'h050, 0, 1);
    vecs[21] = mk(0, 12'h000, 0, 0, 1, 12'h049, 0, 1);

    for (int i = 0; i < 22; i++) begin
      step(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].ps, vecs[i].tk);
      check($sformatf("vec%0d time_out", i), 32'(if0.time_out), 32'(vecs[i].et));
      check($sformatf("vec%0d done", i),     32'(if0.done),     32'(vecs[i].ed));
      check($sformatf("vec%0d running", i),  32'(if0.running),  32'(vecs[i].er));
    end

    // Auto reload: two consecutive expiries on the reloading timer.
    step(1, 12'h002, 0, 0, 0);
    step(0, 12'h000, 1, 0, 0);
    step(0, 12'h000, 0, 0, 1);
    check("reload t1 time_out", 32'(if1.time_out), 32'h001);
    step(0, 12'h000, 0, 0, 1);
    check("reload exp1 done",    32'(if1.done),     1);
    check("reload exp1 time",    32'(if1.time_out), 32'h002);
    check("reload exp1 running", 32'(if1.running),  1);
    check("noreload exp done",   32'(if0.done),     1);
    check("noreload exp running", 32'(if0.running), 0);
    step(0, 12'h000, 0, 0, 1);
    check("reload after done",   32'(if1.done),     0);
    check("reload after time",   32'(if1.time_out), 32'h001);
    step(0, 12'h000, 0, 0, 1);
    check("reload exp2 done",    32'(if1.done),     1);
    check("reload exp2 time",    32'(if1.time_out), 32'h002);

    // Asynchronous reset mid-count at 345.
    step(1, 12'h346, 0, 0, 0);
    step(0, 12'h000, 1, 0, 0);
    step(0, 12'h000, 0, 0, 1);
    check("pre-reset time", 32'(if0.time_out), 32'h345);
    do_reset();
    step(0, 12'h000, 1, 0, 0);
    check("post-reset start running", 32'(if0.running), 0);

    // Load during the expiry cycle.
    step(1, 12'h001, 0, 0, 0);
    step(0, 12'h000, 1, 0, 0);
    step(0, 12'h000, 0, 0, 1);
    check("expiry done", 32'(if0.done), 1);
    step(1, 12'h123, 0, 0, 1);
    check("load@done time",    32'(if0.time_out), 32'h123);
    check("load@done done",    32'(if0.done),     0);
    check("load@done running", 32'(if1.running),  0);
    step(0, 12'h000, 0, 0, 1);
    check("idle tick ignored", 32'(if0.time_out), 32'h123);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      bit ld, st, ps, tk;
      logic [11:0] lv;
      if ($urandom_range(0, 599) == 0) begin
        #2;
        do_reset();
      end
      ld = ($urandom_range(0, 19) == 0);
      st = ($urandom_range(0, 7) == 0);
      ps = ($urandom_range(0, 23) == 0);
      tk = ($urandom_range(0, 1) == 1);
      lv = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 18)) : 12'($urandom);
      step(ld, lv, st, ps, tk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_999.md
# bcd_countdown_999

Three-digit BCD countdown timer, 999 to 000, packed as hundreds/tens/units nibbles. It is the down-counting companion to the team's 0–999 BCD up-counter. Its tick input is driven from an external periodic strobe, typically that counter's wrap pulse. A loaded value counts down once per tick, and expiry raises a one-cycle done pulse, with optional automatic reload.

## Interface
- AUTO_RELOAD, default 0: 1 = on expiry reload the last loaded value and keep running; 0 = stop at 000.
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- tick  input  1  count strobe, one-cycle high per count step; sampled only in RUN
- load  input  1  load load_value into counter and reload register
- load_value  input  12  BCD value [11:8] hundreds, [7:4] tens, [3:0] units
- start  input  1  begin or resume counting
- pause  input  1  suspend counting
- time_out  output  12  current BCD count, registered
- done  output  1  one-cycle pulse on expiry, registered
- running  output  1  high while in RUN, registered

## Operation
- **States:**
  - IDLE: stopped; the count is held.
  - RUN: counting.
  - HOLD: paused; the count is held.
- **Reset:** state IDLE, time_out = 000, reload register = 000, done = 0, running = 0.
- **Priority per cycle:** load > pause > start > tick. Lower-priority inputs in the same cycle are ignored.
- **load (any state):**
  - Each nibble of load_value greater than 9 is clamped to 9.
  - The clamped value is written to both time_out and the reload register.
  - State goes to IDLE, done = 0.
- **start:**
  - IDLE with time_out ≠ 000: go to RUN.
  - IDLE with time_out = 000: ignored, no done.
  - HOLD: go to RUN.
  - RUN: no effect.
- **pause:**
  - RUN: go to HOLD; a coincident tick is dropped.
  - IDLE or HOLD: no effect.
- **tick in RUN, BCD decrement:**
  - units ≠ 0: units − 1.
  - units = 0: units = 9, borrow from tens.
  - tens = 0 on borrow: tens = 9, borrow from hundreds.
  - Nibbles never hold a non-BCD value.
- **Expiry (tick in RUN while time_out = 001):**
  - AUTO_RELOAD = 0: time_out = 000, done = 1 for that cycle, state goes to IDLE.
  - AUTO_RELOAD = 1: time_out = reload register, done = 1, state stays RUN.
  - AUTO_RELOAD = 1 with reload register = 000: behave as AUTO_RELOAD = 0.
- time_out never wraps below 000.
- tick is ignored in IDLE and HOLD.
- done is 0 in every cycle that is not an expiry cycle.

## Timing
- All outputs are registered and update on the rising clk edge that samples the causing input.
- **Latency:**
  - load to time_out: 1 cycle.
  - start to running: 1 cycle.
  - tick to decrement: 1 cycle.
- done is high exactly in the cycle after the expiry tick is sampled, concurrent with time_out = 000 (or the reload value).
- running = 1 exactly while state is RUN; it falls in the same cycle done rises on a non-reload expiry.
- **Back-to-back ticks** (tick held high) decrement once per clock; no minimum spacing is required.
- **Reset mid-count:** asynchronous assertion immediately forces the reset values. The first edge after deassertion behaves as from IDLE.
- **Load while done is high or in RUN:** load wins. done is low the next cycle, and the count restarts from the new value only after a fresh start.

## Test plan
- **Basic countdown:** reset; load 003; start; 3 ticks → time_out 002, 001, 000; done high 1 cycle with 000; running 0.
- **Borrow chain:** load 100; start; 1 tick → 099. Load 010; start; 1 tick → 009.
- **Clamp and zero start:**
  - load 0xAF5 → time_out 995.
  - load 000, start → stays IDLE, running 0, no done.
- **Pause/priority:**
  - In RUN at 050, pause with tick in the same cycle → HOLD, time_out 050.
  - Further ticks are ignored.
  - start → RUN; next tick → 049.
- **AUTO_RELOAD = 1:**
  - load 002; start; 2 ticks → done pulse, time_out 002, running 1.
  - 2 more ticks → second done pulse.
- **Reset/load during run:**
  - Assert reset asynchronously mid-count at 345 → immediately 000, IDLE.
  - Load during the expiry cycle → new value, done low, IDLE.
